// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// hazard stall, flush-to-bubble and saturating bubble/stall counters.
module pipe_stage_skid #(
  parameter int CTRL_W              = 16,
  parameter int DATA_W              = 96,
  parameter int CNT_W               = 16,
  parameter bit ZERO_DATA_ON_BUBBLE = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ValidIn,
  output logic              ReadyOut,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Stall,
  input  logic              Flush,
  output logic              ValidOut,
  input  logic              ReadyIn,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [DATA_W-1:0] DataOut,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  BubbleCount,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;
  logic rdy_eff;
  logic valid_out;

  // Ready is a pure function of state so upstream never sees a combinational
  // path from the downstream ready or the hazard stall.
  assign ReadyOut  = ~Reset & (state_q != ST_TWO);
  assign valid_out = (state_q != ST_EMPTY);
  assign rdy_eff   = ReadyIn & ~Stall;
  assign in_fire   = ValidIn & ReadyOut;
  assign out_fire  = valid_out & rdy_eff;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (Flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_ONE;
            main_ctrl_d = CtrlIn;
            main_data_d = DataIn;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            state_d     = ST_TWO;
            skid_ctrl_d = CtrlIn;
            skid_data_d = DataIn;
          end else if (!in_fire && out_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire && out_fire) begin
            main_ctrl_d = CtrlIn;
            main_data_d = DataIn;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Counters sample the pre-edge output state and are untouched by Flush.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (!valid_out && bubble_cnt_q != CNT_MAX) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
    if (valid_out && !rdy_eff && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_EMPTY;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ValidOut    = valid_out;
  assign CtrlOut     = valid_out ? main_ctrl_q : '0;
  assign Occupancy   = state_q;
  assign BubbleCount = bubble_cnt_q;
  assign StallCount  = stall_cnt_q;

  generate
    if (ZERO_DATA_ON_BUBBLE) begin : g_zero_data
      assign DataOut = valid_out ? main_data_q : '0;
    end else begin : g_hold_data
      assign DataOut = main_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a predictor queues accepted beats,
// a negedge monitor pops and compares whenever the stage hands a beat on.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 96;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              ValidIn;
  logic [CTRL_W-1:0] CtrlIn;
  logic [DATA_W-1:0] DataIn;
  logic              Stall;
  logic              Flush;
  logic              ReadyIn;

  logic              ReadyOut, ValidOut;
  logic [CTRL_W-1:0] CtrlOut;
  logic [DATA_W-1:0] DataOut;
  logic [1:0]        Occupancy;
  logic [15:0]       BubbleCount, StallCount;

  logic              ReadyOut4, ValidOut4;
  logic [CTRL_W-1:0] CtrlOut4;
  logic [DATA_W-1:0] DataOut4;
  logic [1:0]        Occupancy4;
  logic [3:0]        BubbleCount4, StallCount4;

  int    checks   = 0;
  int    failures = 0;
  bit    started  = 1'b0;
  beat_t sb_q[$];

  int exp_occ   = 0;
  int exp_bub   = 0;
  int exp_stall = 0;
  int exp_bub4  = 0;
  int exp_stall4 = 0;

  always #5 Clk = ~Clk;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16), .ZERO_DATA_ON_BUBBLE(1'b1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ValidIn(ValidIn), .ReadyOut(ReadyOut),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .Stall(Stall), .Flush(Flush),
    .ValidOut(ValidOut), .ReadyIn(ReadyIn), .CtrlOut(CtrlOut), .DataOut(DataOut),
    .Occupancy(Occupancy), .BubbleCount(BubbleCount), .StallCount(StallCount)
  );

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4), .ZERO_DATA_ON_BUBBLE(1'b0)
  ) dut4 (
    .Clk(Clk), .Reset(Reset), .ValidIn(ValidIn), .ReadyOut(ReadyOut4),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .Stall(Stall), .Flush(Flush),
    .ValidOut(ValidOut4), .ReadyIn(ReadyIn), .CtrlOut(CtrlOut4), .DataOut(DataOut4),
    .Occupancy(Occupancy4), .BubbleCount(BubbleCount4), .StallCount(StallCount4)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor first, then the predictor advances the expected state for this edge.
  always @(negedge Clk) begin
    if (started) begin
      chk("valid_out", ValidOut, exp_occ != 0);
      chk("occupancy", Occupancy, exp_occ[1:0]);
      chk("ready_out", ReadyOut, !Reset && exp_occ != 2);
      chk("bubble_cnt", BubbleCount, exp_bub);
      chk("stall_cnt", StallCount, exp_stall);
      chk("occupancy4", Occupancy4, exp_occ[1:0]);
      chk("ready_out4", ReadyOut4, !Reset && exp_occ != 2);
      chk("bubble_cnt4", BubbleCount4, exp_bub4);
      chk("stall_cnt4", StallCount4, exp_stall4);
      if (exp_occ == 0) begin
        chk("bubble_ctrl", CtrlOut, 0);
        chk("bubble_data", DataOut, 0);
        chk("bubble_ctrl4", CtrlOut4, 0);
      end
      if (!Reset && ValidOut && ReadyIn && !Stall) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got ctrl %0h data %0h expected none at %0t",
                   CtrlOut, DataOut, $time);
        end else begin
          beat_t b;
          b = sb_q.pop_front();
          chk("out_ctrl", CtrlOut, b.c);
          chk("out_data", DataOut, b.d);
          chk("out_ctrl4", CtrlOut4, b.c);
          chk("out_data4", DataOut4, b.d);
          $display("beat out ctrl=%0h data=%0h t=%0t", CtrlOut, DataOut, $time);
        end
      end

      begin
        bit efire_in, efire_out;
        efire_in  = ValidIn && !Reset && exp_occ != 2;
        efire_out = exp_occ != 0 && ReadyIn && !Stall;
        if (Reset) begin
          exp_occ = 0; exp_bub = 0; exp_stall = 0; exp_bub4 = 0; exp_stall4 = 0;
          sb_q.delete();
        end else begin
          if (exp_occ == 0) begin
            if (exp_bub < 65535) exp_bub++;
            if (exp_bub4 < 15) exp_bub4++;
          end else if (!(ReadyIn && !Stall)) begin
            if (exp_stall < 65535) exp_stall++;
            if (exp_stall4 < 15) exp_stall4++;
          end
          if (Flush) begin
            exp_occ = 0;
            sb_q.delete();
          end else begin
            if (efire_in) begin
              beat_t nb;
              nb.c = CtrlIn;
              nb.d = DataIn;
              sb_q.push_back(nb);
            end
            exp_occ = exp_occ + int'(efire_in) - int'(efire_out);
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic rin, input logic st, input logic fl);
    ValidIn = v; CtrlIn = c; DataIn = d; ReadyIn = rin; Stall = st; Flush = fl;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; ValidIn = 1'b0; CtrlIn = '0; DataIn = '0;
    Stall = 1'b0; Flush = 1'b0; ReadyIn = 1'b1;
    @(posedge Clk);
    #1;
    started = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("reset_ready", ReadyOut, 0);
    chk("reset_occ", Occupancy, 0);
    Reset = 1'b0;
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Streaming burst of four beats
    for (int i = 0; i < 4; i++) begin
      step(1, CTRL_W'(i + 1), DATA_W'(8'hA0 + i), 1, 0, 0);
      chk("stream_ctrl", CtrlOut, i + 1);
    end
    repeat (3) step(0, 0, 0, 1, 0, 0);

    // Skid fill with downstream held off
    step(1, 5, 96'hA5, 0, 0, 0);
    step(1, 6, 96'hA6, 0, 0, 0);
    chk("skid_occ2", Occupancy, 2);
    chk("skid_ready0", ReadyOut, 0);
    step(1, 7, 96'hA7, 0, 0, 0);
    step(1, 7, 96'hA7, 0, 0, 0);
    chk("skid_stall_cnt", StallCount, 3);
    chk("skid_head", CtrlOut, 5);
    step(1, 7, 96'hA7, 1, 0, 0);
    chk("skid_drain6", CtrlOut, 6);
    step(1, 7, 96'hA7, 1, 0, 0);
    chk("skid_drain7", CtrlOut, 7);
    step(0, 0, 0, 1, 0, 0);

    // Hazard stall with one held beat
    step(1, 8, 96'hA8, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1, 0);
      chk("stall_hold", CtrlOut, 8);
    end
    chk("stall_cnt", StallCount, 6);
    step(0, 0, 0, 1, 0, 0);

    // Flush with a full skid and a competing input beat
    step(1, 10, 96'hAA, 0, 0, 0);
    step(1, 11, 96'hAB, 0, 0, 0);
    chk("flush_pre_occ", Occupancy, 2);
    step(1, 9, 96'hA9, 0, 0, 1);
    chk("flush_valid", ValidOut, 0);
    chk("flush_ctrl", CtrlOut, 0);
    chk("flush_data", DataOut, 0);
    chk("flush_occ", Occupancy, 0);
    chk("flush_stall_cnt", StallCount, 8);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Reset while the skid is full
    step(1, 12, 96'hAC, 0, 0, 0);
    step(1, 13, 96'hAD, 0, 0, 0);
    chk("rst_pre_occ", Occupancy, 2);
    Reset = 1'b1;
    step(1, 14, 96'hAE, 0, 0, 0);
    chk("rst_valid", ValidOut, 0);
    chk("rst_ctrl", CtrlOut, 0);
    chk("rst_data", DataOut, 0);
    chk("rst_occ", Occupancy, 0);
    chk("rst_bub", BubbleCount, 0);
    chk("rst_stall", StallCount, 0);
    chk("rst_ready", ReadyOut, 0);
    step(1, 14, 96'hAE, 0, 0, 0);
    Reset = 1'b0; ValidIn = 1'b0; ReadyIn = 1'b1;
    #1;
    chk("post_rst_ready", ReadyOut, 1);

    // Idle run to saturate the narrow counter
    repeat (20) step(0, 0, 0, 1, 0, 0);
    chk("sat_bub4", BubbleCount4, 15);
    chk("idle_bub", BubbleCount, 20);
    step(0, 0, 0, 1, 0, 0);
    chk("sat_hold_bub4", BubbleCount4, 15);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
